logic_unit_arbiter: RTL and testbench

- Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, e.g. the ALU issue path and a branch-compare path.
- Round-robin grant, operand capture, programmable execute latency, and a registered result with a one-cycle done pulse per requester.
- Sits in front of the shared bitwise logic unit inside the ALU cluster.

---
 rtl/logic_unit_arbiter.sv | 128 ++++++++++++
 tb/tb_logic_unit_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter in front of a shared bitwise logic unit.
// Optional LU_ZERO_FLAG_EN adds a registered all-zero flag beside result.
module logic_unit_arbiter #(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
`ifdef LU_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t           state, state_n;
    logic             owner, owner_n;
    logic             ptr, ptr_n;
    logic [3:0]       cnt, cnt_n;
    logic [1:0]       op_q, op_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] lu_out;
    logic             load_res;

    // The unit only ever sees the captured operands.
    always_comb begin
        unique case (op_q)
            2'b00:   lu_out = a_q & b_q;
            2'b01:   lu_out = a_q | b_q;
            2'b10:   lu_out = a_q ^ b_q;
            default: lu_out = ~(a_q | b_q);
        endcase
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        ptr_n    = ptr;
        cnt_n    = cnt;
        op_n     = op_q;
        a_n      = a_q;
        b_n      = b_q;
        load_res = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_n = (req0 && req1) ? ptr : req1;
                    op_n    = owner_n ? op1 : op0;
                    a_n     = owner_n ? a1 : a0;
                    b_n     = owner_n ? b1 : b0;
                    cnt_n   = CNT_INIT;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    load_res = 1'b1;
                    state_n  = DONE;
                end
            end
            DONE: begin
                ptr_n   = ~owner;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            ptr   <= 1'b0;
            cnt   <= 4'd0;
            op_q  <= 2'b00;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            a_q   <= a_n;
            b_q   <= b_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
`ifdef LU_ZERO_FLAG_EN
            zero   <= 1'b0;
`endif
        end else if (load_res) begin
            result <= lu_out;
`ifdef LU_ZERO_FLAG_EN
            zero   <= ~|lu_out;
`endif
        end
    end

    assign busy  = (state != IDLE);
    assign gnt0  = busy && !owner;
    assign gnt1  = busy && owner;
    assign done0 = (state == DONE) && !owner;
    assign done1 = (state == DONE) && owner;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter (EXEC_CYCLES=1 and 3 instances).
module tb_logic_unit_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst3;
    logic        req0, req1, req0_3;
    logic [1:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1, busy;
    logic [31:0] result;
    logic        g0_3, g1_3, d0_3, d1_3, busy_3;
    logic [31:0] res_3;
`ifdef LU_ZERO_FLAG_EN
    logic        zero, zero_3;
`endif

    typedef struct packed {
        logic        who;
        logic [31:0] res;
    } exp_t;

    exp_t sbq[$];
    int   vec = 0;
    int   bad = 0;

    logic_unit_arbiter #(.WIDTH(32), .EXEC_CYCLES(1)) u1 (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result),
`ifdef LU_ZERO_FLAG_EN
        .zero(zero),
`endif
        .busy(busy)
    );

    logic_unit_arbiter #(.WIDTH(32), .EXEC_CYCLES(3)) u3 (
        .clk(clk), .rst(rst3),
        .req0(req0_3), .op0(op0), .a0(a0), .b0(b0),
        .req1(1'b0), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(g0_3), .gnt1(g1_3), .done0(d0_3), .done1(d1_3),
        .result(res_3),
`ifdef LU_ZERO_FLAG_EN
        .zero(zero_3),
`endif
        .busy(busy_3)
    );

    function automatic logic [31:0] lu(input logic [1:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            vec++;
            if ((gnt0 && gnt1) !== 1'b0) begin
                bad++;
                $display("FAIL gnt_mutex gnt0=%b gnt1=%b required not both", gnt0, gnt1);
            end
            vec++;
            if ((done0 && done1) !== 1'b0) begin
                bad++;
                $display("FAIL done_mutex done0=%b done1=%b required not both", done0, done1);
            end
            if (done0 || done1) begin
                vec++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_done done0=%b done1=%b required none", done0, done1);
                end else begin
                    e = sbq.pop_front();
                    if (done1 !== e.who || result !== e.res) begin
                        bad++;
                        $display("FAIL sb_result owner=%b result=%h required owner=%b result=%h",
                                 done1, result, e.who, e.res);
                    end
`ifdef LU_ZERO_FLAG_EN
                    vec++;
                    if (zero !== (e.res == 32'h0)) begin
                        bad++;
                        $display("FAIL zero_flag got=%b required=%b", zero, (e.res == 32'h0));
                    end
`endif
                end
            end
        end
    end

    task automatic wait_done0(input int limit, output int k);
        k = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (done0) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst3 = 1'b1;
        req0 = 0; req1 = 0; req0_3 = 0;
        op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        repeat (2) @(negedge clk);
        vec++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b0 || result !== 32'h0) begin
            bad++;
            $display("FAIL reset_u1 ctl=%b result=%h required 0", {gnt0, gnt1, done0, done1, busy}, result);
        end
        vec++;
        if ({g0_3, g1_3, d0_3, d1_3, busy_3} !== 5'b0 || res_3 !== 32'h0) begin
            bad++;
            $display("FAIL reset_u3 ctl=%b result=%h required 0", {g0_3, g1_3, d0_3, d1_3, busy_3}, res_3);
        end
`ifdef LU_ZERO_FLAG_EN
        vec++;
        if (zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_zero got=%b required=0", zero);
        end
`endif
        rst = 1'b0; rst3 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        int k;
        @(negedge clk);
        op0 = 2'b00; a0 = 32'hF0F0_FF00; b0 = 32'h0FF0_F0F0;
        req0_3 = 1'b1;
        @(posedge clk); #1;
        req0_3 = 1'b0;
        @(posedge clk); #1;
        vec++;
        if (g0_3 !== 1'b1 || busy_3 !== 1'b1) begin
            bad++;
            $display("FAIL mid_exec_gnt gnt0=%b busy=%b required 1 1", g0_3, busy_3);
        end
        rst3 = 1'b1; #1;
        vec++;
        if ({g0_3, g1_3, d0_3, d1_3, busy_3} !== 5'b0 || res_3 !== 32'h0) begin
            bad++;
            $display("FAIL mid_exec_rst ctl=%b result=%h required 0", {g0_3, g1_3, d0_3, d1_3, busy_3}, res_3);
        end
        @(negedge clk); rst3 = 1'b0;
        k = 0;
        repeat (6) begin
            @(negedge clk);
            if (d0_3 || d1_3 || busy_3) k++;
        end
        vec++;
        if (k != 0) begin
            bad++;
            $display("FAIL mid_exec_discard active_cycles=%0d required 0", k);
        end
        req0_3 = 1'b1;
        @(posedge clk); #1;
        req0_3 = 1'b0;
        vec++;
        if (g0_3 !== 1'b1) begin
            bad++;
            $display("FAIL mid_exec_regrant gnt0=%b required 1", g0_3);
        end
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (d0_3) begin
                k = i;
                break;
            end
        end
        vec++;
        if (k != 3 || res_3 !== 32'h00F0_F000) begin
            bad++;
            $display("FAIL mid_exec_done edges=%0d result=%h required 3 00f0f000", k, res_3);
        end
    endtask

    task automatic test_single();
        int k;
        @(negedge clk);
        op0 = 2'b00; a0 = 32'hF0F0_FF00; b0 = 32'h0FF0_F0F0;
        req0 = 1'b1;
        sbq.push_back('{who: 1'b0, res: 32'h00F0_F000});
        @(posedge clk); #1;
        req0 = 1'b0;
        vec++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_gnt gnt0=%b gnt1=%b busy=%b required 1 0 1", gnt0, gnt1, busy);
        end
        wait_done0(10, k);
        vec++;
        if (k != 1 || gnt0 !== 1'b1) begin
            bad++;
            $display("FAIL single_latency edges=%0d gnt0=%b required 1 1", k, gnt0);
        end
        @(posedge clk); #1;
        vec++;
        if (done0 !== 1'b0 || gnt0 !== 1'b0 || busy !== 1'b0 || result !== 32'h00F0_F000) begin
            bad++;
            $display("FAIL single_after done0=%b gnt0=%b busy=%b result=%h required 0 0 0 00f0f000",
                     done0, gnt0, busy, result);
        end
    endtask

    task automatic test_both();
        int  t0, t1;
        bit  s0, s1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        op0 = 2'b01; a0 = 32'h0000_00F0; b0 = 32'h0000_000F;
        op1 = 2'b11; a1 = 32'h0; b1 = 32'h0;
        req0 = 1'b1; req1 = 1'b1;
        sbq.push_back('{who: 1'b0, res: lu(op0, a0, b0)});
        sbq.push_back('{who: 1'b1, res: 32'hFFFF_FFFF});
        s0 = 0; s1 = 0; t0 = 0; t1 = 0;
        for (int c = 0; c < 40 && !(s0 && s1); c++) begin
            @(negedge clk);
            if (done0) begin s0 = 1; t0 = c; req0 = 1'b0; end
            if (done1) begin s1 = 1; t1 = c; req1 = 1'b0; end
        end
        vec++;
        if (!(s0 && s1)) begin
            bad++;
            $display("FAIL both_timeout seen0=%b seen1=%b required 1 1", s0, s1);
        end
        vec++;
        if (t1 - t0 != 3) begin
            bad++;
            $display("FAIL both_spacing cycles=%0d required 3", t1 - t0);
        end
    endtask

    task automatic test_alternate();
        int n;
        @(negedge clk);
        op0 = 2'b00; a0 = 32'hFF00_FF00; b0 = 32'h0F0F_0F0F;
        op1 = 2'b10; a1 = 32'hFFFF_0000; b1 = 32'h0F0F_0F0F;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++)
            sbq.push_back('{who: i[0], res: i[0] ? lu(op1, a1, b1) : lu(op0, a0, b0)});
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (done0 || done1) n++;
        end
        req0 = 1'b0; req1 = 1'b0;
        vec++;
        if (n != 4) begin
            bad++;
            $display("FAIL alt_count dones=%0d required 4", n);
        end
    endtask

    task automatic test_capture();
        int k;
        repeat (2) @(negedge clk);
        op0 = 2'b01; a0 = 32'hA5A5_A5A5; b0 = 32'h0;
        req0 = 1'b1;
        sbq.push_back('{who: 1'b0, res: 32'hA5A5_A5A5});
        @(posedge clk); #1;
        req0 = 1'b0;
        a0 = 32'h1234_5678;
        wait_done0(10, k);
        vec++;
        if (k == 0) begin
            bad++;
            $display("FAIL capture_timeout edges=%0d required done", k);
        end
        repeat (4) @(negedge clk);
        vec++;
        if (result !== 32'hA5A5_A5A5 || busy !== 1'b0) begin
            bad++;
            $display("FAIL capture_hold result=%h busy=%b required a5a5a5a5 0", result, busy);
        end
    endtask

`ifdef LU_ZERO_FLAG_EN
    task automatic test_zero_flag();
        int k;
        @(negedge clk);
        op0 = 2'b10; a0 = 32'hDEAD_BEEF; b0 = 32'hDEAD_BEEF;
        req0 = 1'b1;
        sbq.push_back('{who: 1'b0, res: 32'h0});
        @(posedge clk); #1; req0 = 1'b0;
        wait_done0(10, k);
        repeat (2) @(negedge clk);
        vec++;
        if (zero !== 1'b1 || result !== 32'h0) begin
            bad++;
            $display("FAIL zero_hold zero=%b result=%h required 1 0", zero, result);
        end
        op0 = 2'b01; a0 = 32'h1; b0 = 32'h0;
        req0 = 1'b1;
        sbq.push_back('{who: 1'b0, res: 32'h1});
        @(posedge clk); #1; req0 = 1'b0;
        wait_done0(10, k);
        repeat (2) @(negedge clk);
        vec++;
        if (zero !== 1'b0 || result !== 32'h1) begin
            bad++;
            $display("FAIL zero_clear zero=%b result=%h required 0 1", zero, result);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_single();
        test_both();
        test_alternate();
        test_capture();
`ifdef LU_ZERO_FLAG_EN
        test_zero_flag();
`endif
        repeat (3) @(negedge clk);
        vec++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL sb_drain pending=%0d required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
